// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Holds default widths, the starvation threshold and the writeback port indices.
package regfile_wb_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_STARVE_LIMIT = 3;

    localparam int WB_EXU = 0;
    localparam int WB_LSU = 1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_EXU  = 2'd1,
        GNT_LSU  = 2'd2
    } wb_grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register busy scoreboard.
// Tracks issued-but-uncommitted destinations so decode can stall on RAW/WAW hazards.
module wb_scoreboard
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  clr_en,
    input  logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam int NREG = 2 ** ADDR_WIDTH;

    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;

    // x0 is never tracked, so it can always be issued and is never busy.
    assign issue_ready = !rst && ((issue_rd == '0) || !busy[issue_rd]);
    assign rs1_busy    = busy[rs1_addr];
    assign rs2_busy    = busy[rs2_addr];

    always_comb begin
        busy_nxt = busy;
        if (clr_en) begin
            busy_nxt[clr_addr] = 1'b0;
        end
        if (issue_valid && issue_ready) begin
            busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port controller: arbitrates EXU/LSU writebacks onto one
// registered write port and keeps the busy scoreboard in step with commits.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int SW = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          exu_priority;
    wb_grant_e     grant;

    // LSU normally wins; once the EXU has lost STARVE_LIMIT times in a row it takes priority.
    assign exu_priority = (starve_cnt == SW'(STARVE_LIMIT));

    always_comb begin
        grant = GNT_NONE;
        if (!rst) begin
            if (req0_valid && (exu_priority || !req1_valid)) begin
                grant = GNT_EXU;
            end else if (req1_valid) begin
                grant = GNT_LSU;
            end
        end
    end

    assign req0_ready = (grant == GNT_EXU);
    assign req1_ready = (grant == GNT_LSU);

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant == GNT_EXU) begin
            starve_cnt <= '0;
        end else if (req0_valid && (grant == GNT_LSU) && !exu_priority) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Writes to x0 are accepted but never reach the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (grant == GNT_EXU) begin
            rf_wen   <= (req0_addr != '0);
            rf_waddr <= req0_addr;
            rf_wdata <= req0_data;
        end else if (grant == GNT_LSU) begin
            rf_wen   <= (req1_addr != '0);
            rf_waddr <= req1_addr;
            rf_wdata <= req1_data;
        end else begin
            rf_wen   <= 1'b0;
        end
    end

    wb_scoreboard #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .clr_en     (rf_wen),
        .clr_addr   (rf_waddr)
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// random traffic, all compared against a behavioural model of the write port.
module tb_regfile_wb_arbiter;

    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_busy, rs2_busy;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int errors = 0;
    int checks = 0;

    // Reference model state: busy flags, consecutive EXU losses, expected write port.
    bit          busy_m [32];
    int          lost_m;
    bit          m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    bit exp_g0, exp_g1, exp_ir;
    logic obs_g0, obs_g1, obs_ir, obs_rs1, obs_rs2;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(
        .ADDR_WIDTH(5),
        .DATA_WIDTH(32),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    task automatic check1(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        check1("rf_wen", rf_wen, m_wen);
        check1("rf_waddr", rf_waddr, m_waddr);
        check1("rf_wdata", rf_wdata, m_wdata);
    endtask

    // Inputs are already driven at a negedge; check the combinational outputs,
    // advance the model across the posedge, then check the registered port.
    task automatic applyStimulus();
        #1;
        if (rst) begin
            exp_g0 = 0;
            exp_g1 = 0;
            exp_ir = 0;
        end else begin
            exp_g0 = req0_valid && (lost_m >= LIMIT || !req1_valid);
            exp_g1 = req1_valid && !exp_g0;
            exp_ir = (issue_rd == 0) || !busy_m[issue_rd];
        end
        obs_g0  = req0_ready;
        obs_g1  = req1_ready;
        obs_ir  = issue_ready;
        obs_rs1 = rs1_busy;
        obs_rs2 = rs2_busy;
        check1("req0_ready", obs_g0, exp_g0);
        check1("req1_ready", obs_g1, exp_g1);
        check1("issue_ready", obs_ir, exp_ir);
        check1("rs1_busy", obs_rs1, busy_m[rs1_addr]);
        check1("rs2_busy", obs_rs2, busy_m[rs2_addr]);
        @(posedge clk);
        if (rst) begin
            foreach (busy_m[i]) busy_m[i] = 0;
            lost_m  = 0;
            m_wen   = 0;
            m_waddr = '0;
            m_wdata = '0;
        end else begin
            if (m_wen) busy_m[m_waddr] = 0;
            if (issue_valid && exp_ir && issue_rd != 0) busy_m[issue_rd] = 1;
            if (exp_g0) lost_m = 0;
            else if (req0_valid && exp_g1 && lost_m < LIMIT) lost_m++;
            if (exp_g0) begin
                m_wen = (req0_addr != 0);
                m_waddr = req0_addr;
                m_wdata = req0_data;
            end else if (exp_g1) begin
                m_wen = (req1_addr != 0);
                m_waddr = req1_addr;
                m_wdata = req1_data;
            end else begin
                m_wen = 0;
            end
        end
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        bit seq [8];
        seq = '{1, 1, 1, 0, 1, 1, 1, 0};
        rst = 1; issue_valid = 0; issue_rd = 0; rs1_addr = 0; rs2_addr = 0;
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
        foreach (busy_m[i]) busy_m[i] = 0;
        lost_m = 0; m_wen = 0; m_waddr = 0; m_wdata = 0;

        @(negedge clk);
        applyStimulus();
        rst = 0;
        check1("reset_wen", rf_wen, 0);
        check1("reset_wdata", rf_wdata, 0);

        // Single EXU write.
        req0_valid = 1; req0_addr = 5; req0_data = 32'hDEADBEEF;
        applyStimulus();
        check1("exu_grant", obs_g0, 1);
        check1("exu_wen", rf_wen, 1);
        check1("exu_waddr", rf_waddr, 5);
        check1("exu_wdata", rf_wdata, 32'hDEADBEEF);
        req0_valid = 0;
        applyStimulus();
        check1("exu_wen_drop", rf_wen, 0);

        // Both requesters continuously valid: starvation rotation.
        for (int i = 0; i < 8; i++) begin
            req0_valid = 1; req0_addr = 5'd10; req0_data = 32'h100 + i;
            req1_valid = 1; req1_addr = 5'd11; req1_data = 32'h200 + i;
            applyStimulus();
            check1("grant_seq", obs_g1, seq[i]);
        end
        req0_valid = 0; req1_valid = 0;
        applyStimulus();

        // RAW/WAW tracking on x7.
        issue_valid = 1; issue_rd = 7; rs1_addr = 7;
        applyStimulus();
        issue_valid = 0;
        applyStimulus();
        check1("rs1_busy_set", obs_rs1, 1);
        issue_valid = 1;
        applyStimulus();
        check1("waw_stall", obs_ir, 0);
        issue_valid = 0; req1_valid = 1; req1_addr = 7; req1_data = 32'h77;
        applyStimulus();
        req1_valid = 0;
        applyStimulus();
        check1("rs1_busy_during_wen", obs_rs1, 1);
        issue_valid = 1;
        applyStimulus();
        check1("rs1_busy_cleared", obs_rs1, 0);
        check1("reissue_ok", obs_ir, 1);
        issue_valid = 0;
        applyStimulus();

        // Writes and issues to x0.
        req0_valid = 1; req0_addr = 0; req0_data = 32'h1234;
        applyStimulus();
        check1("x0_grant", obs_g0, 1);
        check1("x0_wen", rf_wen, 0);
        req0_valid = 0; issue_valid = 1; issue_rd = 0; rs1_addr = 0;
        applyStimulus();
        check1("x0_issue_ready", obs_ir, 1);
        issue_valid = 0;
        applyStimulus();
        check1("x0_busy", obs_rs1, 0);

        // Reset with writes pending.
        issue_valid = 1; issue_rd = 3;
        applyStimulus();
        issue_rd = 4;
        applyStimulus();
        issue_valid = 0; req0_valid = 1; req0_addr = 3; req0_data = 32'h33;
        applyStimulus();
        rst = 1; req0_addr = 4; req0_data = 32'h44;
        applyStimulus();
        check1("rst_ready", obs_g0, 0);
        rst = 0; req0_valid = 0; rs1_addr = 3; rs2_addr = 4;
        applyStimulus();
        check1("rst_busy3", obs_rs1, 0);
        check1("rst_busy4", obs_rs2, 0);
        check1("rst_no_write", rf_wen, 0);

        // Clear of x8 and set of x9 on the same edge.
        issue_valid = 1; issue_rd = 8;
        applyStimulus();
        issue_valid = 0; req1_valid = 1; req1_addr = 8; req1_data = 32'h88;
        applyStimulus();
        req1_valid = 0; issue_valid = 1; issue_rd = 9;
        applyStimulus();
        issue_valid = 0; rs1_addr = 9; rs2_addr = 8;
        applyStimulus();
        check1("set_busy9", obs_rs1, 1);
        check1("clr_busy8", obs_rs2, 0);

        // Random traffic; requesters hold their request until it transfers.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 60) == 0);
            if (!(req0_valid && !exp_g0)) begin
                req0_valid = $urandom_range(0, 1);
                req0_addr = 5'($urandom_range(0, 31));
                req0_data = $urandom;
            end
            if (!(req1_valid && !exp_g1)) begin
                req1_valid = $urandom_range(0, 1);
                req1_addr = 5'($urandom_range(0, 31));
                req1_data = $urandom;
            end
            issue_valid = $urandom_range(0, 1);
            issue_rd = 5'($urandom_range(0, 31));
            rs1_addr = 5'($urandom_range(0, 31));
            rs2_addr = 5'($urandom_range(0, 31));
            applyStimulus();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
